// File: rtl/apb_arbiter.sv
// Round-robin arbiter sharing one APB completer between NUM_MASTERS requesters.
// Optional access-phase watchdog: define APB_ARB_TIMEOUT_EN (limit TIMEOUT_CYCLES).
module apb_arbiter #(
  parameter int unsigned NUM_MASTERS    = 2,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_MASTERS-1:0]        m_psel,
  input  logic [NUM_MASTERS-1:0]        m_penable,
  input  logic [NUM_MASTERS-1:0]        m_pwrite,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_paddr,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_pwdata,
  output logic [NUM_MASTERS-1:0]        m_pready,
  output logic [DATA_W-1:0]             m_prdata,
  output logic                          m_pslverr,
  output logic                          s_psel,
  output logic                          s_penable,
  output logic                          s_pwrite,
  output logic [ADDR_W-1:0]             s_paddr,
  output logic [DATA_W-1:0]             s_pwdata,
  input  logic                          s_pready,
  input  logic [DATA_W-1:0]             s_prdata,
  input  logic                          s_pslverr
);

  localparam int unsigned IW = $clog2(NUM_MASTERS);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t        state;
  logic [IW-1:0] last_grant;
  logic [IW-1:0] pick;
  logic [IW-1:0] idx;
  logic          found;
  logic          unused_ok;

`ifdef APB_ARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] tcnt;
  assign unused_ok = ^m_penable;
`else
  assign unused_ok = ^{m_penable, TIMEOUT_CYCLES[0]};
`endif

  // First requester found searching upward from last_grant+1, wrapping.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = '0;
    for (int unsigned i = 1; i <= NUM_MASTERS; i++) begin
      idx = IW'((32'(last_grant) + i) % NUM_MASTERS);
      if (!found && m_psel[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= IW'(NUM_MASTERS - 1);
      s_psel     <= 1'b0;
      s_penable  <= 1'b0;
      s_pwrite   <= 1'b0;
      s_paddr    <= '0;
      s_pwdata   <= '0;
      m_pready   <= '0;
      m_prdata   <= '0;
      m_pslverr  <= 1'b0;
`ifdef APB_ARB_TIMEOUT_EN
      tcnt       <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            last_grant <= pick;
            s_psel     <= 1'b1;
            s_penable  <= 1'b0;
            s_pwrite   <= m_pwrite[pick];
            s_paddr    <= m_paddr[pick*ADDR_W +: ADDR_W];
            s_pwdata   <= m_pwdata[pick*DATA_W +: DATA_W];
            state      <= SETUP;
          end
        end
        SETUP: begin
          s_penable <= 1'b1;
`ifdef APB_ARB_TIMEOUT_EN
          tcnt      <= '0;
`endif
          state     <= ACCESS;
        end
        ACCESS: begin
          if (s_pready) begin
            s_psel               <= 1'b0;
            s_penable            <= 1'b0;
            m_pready[last_grant] <= 1'b1;
            m_prdata             <= s_prdata;
            m_pslverr            <= s_pslverr;
            state                <= RESP;
          end
`ifdef APB_ARB_TIMEOUT_EN
          else if (tcnt + 1'b1 == CW'(TIMEOUT_CYCLES)) begin
            s_psel               <= 1'b0;
            s_penable            <= 1'b0;
            m_pready[last_grant] <= 1'b1;
            m_prdata             <= '0;
            m_pslverr            <= 1'b1;
            state                <= RESP;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
`endif
        end
        RESP: begin
          m_pready  <= '0;
          m_pslverr <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_arbiter.sv
// Directed bench for apb_arbiter: timeline model of grants checked every cycle,
// plus literal expectations on responses, latencies and completer address order.
module tb_apb_arbiter;
  localparam int NM = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NM-1:0]     m_psel, m_penable, m_pwrite;
  logic [NM*AW-1:0]  m_paddr;
  logic [NM*DW-1:0]  m_pwdata;
  logic [NM-1:0]     m_pready;
  logic [DW-1:0]     m_prdata;
  logic              m_pslverr;
  logic              s_psel, s_penable, s_pwrite;
  logic [AW-1:0]     s_paddr;
  logic [DW-1:0]     s_pwdata;
  logic              s_pready;
  logic [DW-1:0]     s_prdata;
  logic              s_pslverr;

  always #5 clk = ~clk;

  apb_arbiter #(.NUM_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
    .m_paddr(m_paddr), .m_pwdata(m_pwdata),
    .m_pready(m_pready), .m_prdata(m_prdata), .m_pslverr(m_pslverr),
    .s_psel(s_psel), .s_penable(s_penable), .s_pwrite(s_pwrite),
    .s_paddr(s_paddr), .s_pwdata(s_pwdata),
    .s_pready(s_pready), .s_prdata(s_prdata), .s_pslverr(s_pslverr)
  );

  typedef struct {logic [31:0] addr; logic wr; logic [31:0] wdata;} req_t;
  typedef struct {int m; logic [31:0] rd; logic err; int ts; int td;} cmp_t;

  req_t        mq[NM][$];
  cmp_t        log_q[$];
  logic [31:0] setup_addr[$];
  logic [31:0] exp_addr[$];
  int          tbl_w[64];
  logic [31:0] tbl_rd[64];
  logic        tbl_err[64];
  int          tn = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc = 0;

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, a, e);
    end
  endtask

  // Model: a transfer granted at the edge entering cycle 'start' occupies
  // SETUP at start, ACCESS start+1..start+1+w, RESP start+2+w, IDLE start+3+w.
  bit          have = 0, busy = 0, mfound;
  int          start = 0, w = 0, g = 0, lastg = NM - 1, gn = 0, pj;
  logic [31:0] rd = '0, prev_rd = '0, maddr = '0, mwdata = '0;
  logic        mwr = 1'b0, merr = 1'b0;

  initial begin : model
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        have = 0; busy = 0; lastg = NM - 1; prev_rd = '0;
      end else begin
        cyc++;
        if (busy && (cyc - 1 >= start + 3 + w)) busy = 0;
        mfound = 0;
        if (!busy) begin
          for (int k = 1; k <= NM; k++) begin
            pj = (lastg + k) % NM;
            if (!mfound && m_psel[pj]) begin
              mfound = 1;
              prev_rd = have ? rd : prev_rd;
              have = 1; busy = 1; start = cyc; g = pj; lastg = pj;
              maddr = m_paddr[pj*AW +: AW];
              mwdata = m_pwdata[pj*DW +: DW];
              mwr = m_pwrite[pj];
              w = tbl_w[gn]; rd = tbl_rd[gn]; merr = tbl_err[gn];
`ifdef APB_ARB_TIMEOUT_EN
              if (w >= TO) begin w = TO - 1; rd = '0; merr = 1'b1; end
`endif
              gn++;
            end
          end
        end
      end
    end
  end

  initial begin : compare
    logic [NM-1:0] e_rdy;
    int m;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        m = cyc;
        e_rdy = '0;
        if (have && m == start + 2 + w) e_rdy[g] = 1'b1;
        chk("s_psel", s_psel, have && m >= start && m <= start + 1 + w);
        chk("s_penable", s_penable, have && m >= start + 1 && m <= start + 1 + w);
        chk("s_paddr", s_paddr, have ? maddr : 32'h0);
        chk("s_pwdata", s_pwdata, have ? mwdata : 32'h0);
        chk("s_pwrite", s_pwrite, have ? mwr : 1'b0);
        chk("m_pready", m_pready, e_rdy);
        chk("m_pslverr", m_pslverr, have && m == start + 2 + w && merr);
        chk("m_prdata", m_prdata, (have && m >= start + 2 + w) ? rd : prev_rd);
        if (s_psel && !s_penable) setup_addr.push_back(s_paddr);
      end
    end
  end

  // Completer: ready after tbl_w[] low ACCESS cycles; junk data/error while not ready.
  initial begin : completer
    int acc, cur, sn;
    acc = 0; cur = 0; sn = 0;
    s_pready = 1'b0; s_prdata = '0; s_pslverr = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        acc = 0; s_pready = 1'b0;
      end else begin
        if (s_psel && !s_penable) begin cur = sn; sn++; acc = 0; end
        if (s_psel && s_penable) begin
          if (acc == tbl_w[cur]) begin
            s_pready = 1'b1; s_prdata = tbl_rd[cur]; s_pslverr = tbl_err[cur];
          end else begin
            s_pready = 1'b0; s_prdata = 32'hBAD0_0000 + 32'(acc); s_pslverr = 1'b1;
          end
          acc++;
        end else begin
          s_pready = 1'b0; s_prdata = 32'hFFFF_FFFF; s_pslverr = 1'b1;
        end
      end
    end
  end

  // Requesters: hold setup/access until own pready, then start the next queued transfer.
  initial begin : requesters
    logic [NM-1:0] saw;
    logic [31:0]   saw_rd;
    logic          saw_err;
    int            saw_cyc;
    bit            act[NM];
    int            t_set[NM];
    req_t          r;
    cmp_t          c;
    m_psel = '0; m_penable = '0; m_pwrite = '0; m_paddr = '0; m_pwdata = '0;
    for (int i = 0; i < NM; i++) begin act[i] = 0; t_set[i] = 0; end
    forever begin
      @(negedge clk);
      saw = m_pready; saw_rd = m_prdata; saw_err = m_pslverr; saw_cyc = cyc;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        for (int i = 0; i < NM; i++) begin act[i] = 0; mq[i].delete(); end
        m_psel = '0; m_penable = '0;
      end else begin
        for (int i = 0; i < NM; i++) begin
          if (act[i] && m_penable[i] && saw[i]) begin
            c.m = i; c.rd = saw_rd; c.err = saw_err; c.ts = t_set[i]; c.td = saw_cyc;
            log_q.push_back(c);
            act[i] = 0;
          end
          if (act[i]) begin
            m_penable[i] = 1'b1;
          end else if (mq[i].size() > 0) begin
            r = mq[i].pop_front();
            act[i] = 1; t_set[i] = cyc;
            m_psel[i] = 1'b1; m_penable[i] = 1'b0; m_pwrite[i] = r.wr;
            m_paddr[i*AW +: AW] = r.addr;
            m_pwdata[i*DW +: DW] = r.wdata;
          end else begin
            m_psel[i] = 1'b0; m_penable[i] = 1'b0;
          end
        end
      end
    end
  end

  task automatic add_resp(input int wt, input logic [31:0] d, input logic e);
    tbl_w[tn] = wt; tbl_rd[tn] = d; tbl_err[tn] = e; tn++;
  endtask

  task automatic push(input int m, input logic [31:0] a, input logic wr, input logic [31:0] d);
    req_t r;
    r.addr = a; r.wr = wr; r.wdata = d;
    mq[m].push_back(r);
    exp_addr.push_back(a);
  endtask

  task automatic wait_n(input int n, input int budget);
    int c = 0;
    while (log_q.size() < n && c < budget) begin @(negedge clk); c++; end
    chk("wait_done", log_q.size() >= n, 1'b1);
    repeat (2) @(negedge clk);
  endtask

  task automatic chk_log(input int k, input int m, input logic [31:0] d, input logic e, input int lat);
    if (k >= log_q.size()) begin
      chk("resp_present", log_q.size(), k + 1);
    end else begin
      chk("resp_master", log_q[k].m, m);
      chk("resp_prdata", log_q[k].rd, d);
      chk("resp_pslverr", log_q[k].err, e);
      if (lat >= 0) chk("resp_latency", log_q[k].td - log_q[k].ts, lat);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  initial begin : main
    int lb, c;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_ctrl", {s_psel, s_penable, s_pwrite, m_pslverr}, 4'b0);
    chk("reset_pready", m_pready, 2'b0);
    chk("reset_prdata", m_prdata, 32'h0);
    chk("reset_paddr", s_paddr, 32'h0);
    #2 rst_n = 1'b1;

    // single zero-wait read
    add_resp(0, 32'hDEAD_BEEF, 1'b0);
    push(0, 32'h40, 1'b0, 32'h0);
    wait_n(1, 40);
    chk_log(0, 0, 32'hDEAD_BEEF, 1'b0, 3);

    // simultaneous requests after reset: 0 first, 1 waits four extra cycles
    do_reset();
    lb = log_q.size();
    add_resp(0, 32'h1111_1111, 1'b0);
    add_resp(0, 32'h2222_2222, 1'b0);
    push(0, 32'h10, 1'b1, 32'h11);
    push(1, 32'h20, 1'b0, 32'h0);
    wait_n(lb + 2, 60);
    chk_log(lb, 0, 32'h1111_1111, 1'b0, 3);
    chk_log(lb + 1, 1, 32'h2222_2222, 1'b0, 7);

    // sustained contention: strict alternation
    lb = log_q.size();
    for (int k = 0; k < 6; k++) add_resp(0, 32'h3000_0000 + 32'(k), 1'b0);
    for (int k = 0; k < 3; k++) begin
      push(0, 32'h100 + 32'(4 * k), 1'b0, 32'h0);
      push(1, 32'h200 + 32'(4 * k), 1'b1, 32'hA0 + 32'(k));
    end
    wait_n(lb + 6, 150);
    for (int k = 0; k < 6; k++) chk_log(lb + k, k % 2, 32'h3000_0000 + 32'(k), 1'b0, -1);

    // three wait states then error
    lb = log_q.size();
    add_resp(3, 32'h0BAD_F00D, 1'b1);
    push(0, 32'h300, 1'b0, 32'h0);
    wait_n(lb + 1, 40);
    chk_log(lb, 0, 32'h0BAD_F00D, 1'b1, 6);

`ifdef APB_ARB_TIMEOUT_EN
    lb = log_q.size();
    add_resp(100, 32'h7777_7777, 1'b0);
    push(1, 32'h400, 1'b0, 32'h0);
    wait_n(lb + 1, 60);
    chk_log(lb, 1, 32'h0, 1'b1, 10);
    add_resp(0, 32'h5A5A_5A5A, 1'b0);
    push(0, 32'h404, 1'b0, 32'h0);
    wait_n(lb + 2, 40);
    chk_log(lb + 1, 0, 32'h5A5A_5A5A, 1'b0, 3);
`endif

    // reset during ACCESS of a requester-0 transfer
    lb = log_q.size();
    add_resp(5, 32'h6666_6666, 1'b0);
    push(0, 32'h500, 1'b0, 32'h0);
    c = 0;
    while (!s_penable && c < 20) begin @(negedge clk); c++; end
    chk("reach_access", s_penable, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_ctrl", {s_psel, s_penable, s_pwrite, m_pslverr}, 4'b0);
    chk("rst_async_pready", m_pready, 2'b0);
    chk("rst_async_paddr", s_paddr, 32'h0);
    chk("rst_async_prdata", m_prdata, 32'h0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_no_resp", log_q.size(), lb);
    add_resp(0, 32'h6000_0000, 1'b0);
    add_resp(0, 32'h7000_0000, 1'b0);
    push(0, 32'h600, 1'b0, 32'h0);
    push(1, 32'h700, 1'b0, 32'h0);
    wait_n(lb + 2, 60);
    chk_log(lb, 0, 32'h6000_0000, 1'b0, 3);
    chk_log(lb + 1, 1, 32'h7000_0000, 1'b0, 7);

    chk("setup_count", setup_addr.size(), exp_addr.size());
    for (int k = 0; k < exp_addr.size(); k++) begin
      if (k < setup_addr.size()) chk("setup_addr", setup_addr[k], exp_addr[k]);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/apb_arbiter.md
Name: apb_arbiter

Overview:
- Shares one APB completer port (the register fabric behind the cpu apbReg link) between NUM_MASTERS APB requesters, for example the cpu plus a debug/DMA requester.
- Round-robin arbitration between requesters.
- Replays the granted requester's transfer on the shared port, then returns the completer's response to that requester only.
- Non-granted requesters stall in their APB access phase, with pready low, until served.

Parameters:
- NUM_MASTERS, 2, number of APB requesters (range 2..8).
- ADDR_W, 32, APB address width.
- DATA_W, 32, APB data width.
- TIMEOUT_CYCLES, 256, access-phase watchdog limit; used only with APB_ARB_TIMEOUT_EN.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset; asynchronous, active-low.
- m_psel  input  NUM_MASTERS  per-requester psel.
- m_penable  input  NUM_MASTERS  per-requester penable.
- m_pwrite  input  NUM_MASTERS  per-requester pwrite.
- m_paddr  input  NUM_MASTERS*ADDR_W  requester i occupies bits [i*ADDR_W +: ADDR_W].
- m_pwdata  input  NUM_MASTERS*DATA_W  requester i occupies bits [i*DATA_W +: DATA_W].
- m_pready  output  NUM_MASTERS  per-requester pready, one-hot or zero.
- m_prdata  output  DATA_W  shared read data; valid only with the asserted m_pready bit.
- m_pslverr  output  1  shared error; valid only with the asserted m_pready bit.
- s_psel  output  1  completer psel.
- s_penable  output  1  completer penable.
- s_pwrite  output  1  completer pwrite.
- s_paddr  output  ADDR_W  completer paddr.
- s_pwdata  output  DATA_W  completer pwdata.
- s_pready  input  1  completer pready.
- s_prdata  input  DATA_W  completer prdata.
- s_pslverr  input  1  completer pslverr.

Behaviour:
- Clocking and reset: single clk domain.
- Reset (rst_n low, asynchronous):
  - All outputs go to 0 immediately.
  - FSM goes to IDLE.
  - Round-robin pointer last_grant is set to NUM_MASTERS-1, so requester 0 has first priority.
- All outputs are registered.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - Requests are m_psel bits; penable is ignored for arbitration.
  - If any request is present, grant the first requesting index searching upward from last_grant+1 (mod NUM_MASTERS).
  - On grant: latch grant index g, m_paddr[g], m_pwrite[g], m_pwdata[g]; update last_grant to g; go to SETUP.
- SETUP (exactly one cycle): s_psel=1, s_penable=0, latched address/write/data on s_*; go to ACCESS.
- ACCESS:
  - s_psel=1, s_penable=1.
  - Hold while s_pready=0.
  - On s_pready=1: capture s_prdata and s_pslverr; go to RESP.
  - s_prdata and s_pslverr are ignored when s_pready=0.
- RESP (exactly one cycle):
  - s_psel=0 and s_penable=0.
  - m_pready[g]=1; m_prdata and m_pslverr show the captured values.
  - Next state is IDLE; no arbitration happens in RESP, so the still-asserted m_psel[g] is not regranted.
- Latency:
  - With a zero-wait completer, requester setup in cycle T produces m_pready in cycle T+3.
  - Each completer wait state adds one cycle.
  - Idle gap on the completer between transfers is 2 cycles (RESP, IDLE).
- Fairness: a continuously requesting requester is served at most once per NUM_MASTERS grants when others are requesting.
- m_prdata is updated only on completion and holds its value otherwise. m_pslverr is 0 outside RESP.
- Write transfers return m_prdata equal to the captured s_prdata, which requesters ignore.
- If m_psel[g] drops before RESP (protocol violation): the completer transfer still finishes, m_pready[g] still pulses, and there is no abort.
- Reset in the middle of a transfer: s_psel drops asynchronously, the transfer is lost, and no response is given.

Optional Feature:
- Macro: APB_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to ACCESS and increments each ACCESS cycle with s_pready=0.
  - When it reaches TIMEOUT_CYCLES, go to RESP with m_pslverr=1 and m_prdata=0.
  - s_psel and s_penable drop on that transition.
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
- Not defined: ACCESS waits indefinitely for s_pready, and no counter logic exists.

Test Plan:
- Single read, zero wait: m_psel[0] addr 0x40 at T, s_prdata=0xDEADBEEF -> s_psel rises at T+1, s_penable at T+2; m_pready[0]=1 at T+3 with m_prdata=0xDEADBEEF and m_pslverr=0.
- Simultaneous requests after reset: requester 0 writes 0x10/0x11, requester 1 reads 0x20 -> requester 0 is served first, then requester 1; s_paddr sequence 0x10 then 0x20; m_pready[1] stays 0 until requester 1's RESP.
- Sustained contention: both requesters re-request immediately for 6 transfers -> grants alternate 0,1,0,1,0,1.
- Wait states and error: s_pready held low 3 ACCESS cycles, then high with s_pslverr=1 -> m_pready at T+6 with m_pslverr=1; the completer signals are held stable throughout.
- Timeout (APB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8): s_pready never asserted -> after 8 ACCESS cycles, RESP with m_pslverr=1 and m_prdata=0; the next request is served normally.
- Reset mid-ACCESS: rst_n low during ACCESS -> all outputs go to 0 in the same cycle; after release, requester 0 has priority.
